// File: rtl/jam_pkg.sv
// Shared defaults, FSM state encoding and perm-bus field helper for the
// job-assignment permutation scheduler.
package jam_pkg;

    localparam int JAM_N     = 8;
    localparam int JAM_IDX_W = 3;
    localparam int JAM_CNT_W = 16;

    typedef enum logic [2:0] {
        IDLE,
        EMIT,
        FIND_PT,
        FIND_MIN,
        SWAP_REV,
        DONE
    } jam_state_e;

    // Bit offset of a worker's job-index field inside the packed perm bus.
    function automatic int jam_lsb(input int worker, input int idx_w);
        return worker * idx_w;
    endfunction

endpackage

// File: rtl/jam_swap_reverse.sv
// Next-permutation datapath: swap arr[pivot] with arr[q], then reverse the
// suffix arr[pivot+1..N-1], all as one combinational mux network.
module jam_swap_reverse #(
    parameter int N     = 8,
    parameter int IDX_W = 3
) (
    input  logic [IDX_W-1:0] arr_in  [N],
    input  logic [IDX_W-1:0] pivot,
    input  logic [IDX_W-1:0] q,
    output logic [IDX_W-1:0] arr_out [N]
);

    for (genvar gi = 0; gi < N; gi++) begin : g_out
        logic [IDX_W-1:0] mirror;

        // Suffix slot gi takes the swapped array's element at N-1-(gi-pivot-1);
        // that source is q, whose swapped value is the old pivot element.
        assign mirror = IDX_W'(N + int'(pivot) - gi);

        assign arr_out[gi] = (gi < int'(pivot))  ? arr_in[gi]    :
                             (gi == int'(pivot)) ? arr_in[q]     :
                             (mirror == q)       ? arr_in[pivot] :
                                                   arr_in[mirror];
    end

endmodule

// File: rtl/jam_perm_scheduler.sv
// Walks all N! worker->job assignments in lexicographic order and presents
// each one to the cost evaluator over a valid/ready handshake.
module jam_perm_scheduler
    import jam_pkg::*;
#(
    parameter int N     = JAM_N,
    parameter int IDX_W = JAM_IDX_W,
    parameter int CNT_W = JAM_CNT_W
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               start,
    input  logic               abort,
    output logic               perm_valid,
    input  logic               perm_ready,
    output logic [N*IDX_W-1:0] perm,
    output logic               perm_last,
    output logic               busy,
    output logic               done,
    output logic [CNT_W-1:0]   perm_count
);

    jam_state_e       state_reg;
    logic [IDX_W-1:0] arr_reg [N];
    logic [IDX_W-1:0] arr_next [N];
    logic [IDX_W-1:0] p_reg;
    logic [IDX_W-1:0] q_reg;
    logic [IDX_W-1:0] pivot_reg;
    logic [IDX_W-1:0] p_plus1;
    logic             valid_reg;
    logic             busy_reg;
    logic             done_reg;
    logic [CNT_W-1:0] count_reg;
    logic [N-2:0]     desc;

    jam_swap_reverse #(
        .N     (N),
        .IDX_W (IDX_W)
    ) u_swap_reverse (
        .arr_in  (arr_reg),
        .pivot   (pivot_reg),
        .q       (q_reg),
        .arr_out (arr_next)
    );

    for (genvar gi = 0; gi < N; gi++) begin : g_pack
        assign perm[jam_lsb(gi, IDX_W) +: IDX_W] = arr_reg[gi];
    end

    for (genvar gi = 0; gi < N - 1; gi++) begin : g_desc
        assign desc[gi] = arr_reg[gi] > arr_reg[gi+1];
    end

    // Strictly descending is only ever reached by the final permutation.
    assign perm_last  = valid_reg & (&desc);
    assign p_plus1    = p_reg + IDX_W'(1);
    assign perm_valid = valid_reg;
    assign busy       = busy_reg;
    assign done       = done_reg;
    assign perm_count = count_reg;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_reg <= IDLE;
            for (int i = 0; i < N; i++) begin
                arr_reg[i] <= IDX_W'(i);
            end
            p_reg     <= '0;
            q_reg     <= '0;
            pivot_reg <= '0;
            valid_reg <= 1'b0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            count_reg <= '0;
        end else if (abort) begin
            // Abort wins over start and over a same-cycle transfer; count holds.
            state_reg <= IDLE;
            for (int i = 0; i < N; i++) begin
                arr_reg[i] <= IDX_W'(i);
            end
            valid_reg <= 1'b0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE, DONE: begin
                    if (start) begin
                        for (int i = 0; i < N; i++) begin
                            arr_reg[i] <= IDX_W'(i);
                        end
                        count_reg <= '0;
                        state_reg <= EMIT;
                        valid_reg <= 1'b1;
                        busy_reg  <= 1'b1;
                        done_reg  <= 1'b0;
                    end
                end
                EMIT: begin
                    if (perm_ready) begin
                        if (count_reg != '1) begin
                            count_reg <= count_reg + CNT_W'(1);
                        end
                        valid_reg <= 1'b0;
                        if (perm_last) begin
                            state_reg <= DONE;
                            busy_reg  <= 1'b0;
                            done_reg  <= 1'b1;
                        end else begin
                            state_reg <= FIND_PT;
                            p_reg     <= IDX_W'(N - 2);
                        end
                    end
                end
                FIND_PT: begin
                    if (arr_reg[p_reg] < arr_reg[p_plus1]) begin
                        pivot_reg <= p_reg;
                        q_reg     <= IDX_W'(N - 1);
                        state_reg <= FIND_MIN;
                    end else begin
                        p_reg <= p_reg - IDX_W'(1);
                    end
                end
                FIND_MIN: begin
                    if (arr_reg[q_reg] > arr_reg[pivot_reg]) begin
                        state_reg <= SWAP_REV;
                    end else begin
                        q_reg <= q_reg - IDX_W'(1);
                    end
                end
                SWAP_REV: begin
                    arr_reg   <= arr_next;
                    state_reg <= EMIT;
                    valid_reg <= 1'b1;
                end
                default: begin
                    state_reg <= IDLE;
                    valid_reg <= 1'b0;
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b0;
                end
            endcase
        end
    end

endmodule
